// File: rtl/rd_sel_pkg.sv
// Shared definitions for the per-port read SRAM selector and its helpers.
package rd_sel_pkg;

  localparam int unsigned SRAM_IDX_W  = 5;
  localparam int unsigned SRAM_SEL_W  = 6;
  localparam int unsigned HEAD_WAIT_W = 10;

  localparam logic [SRAM_SEL_W-1:0] SRAM_NONE = 6'd32;

  // Shared with the head-wait tracker that produces head_wait upstream.
  typedef logic [HEAD_WAIT_W-1:0] head_wait_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } rd_sel_state_e;

endpackage

// File: rtl/rd_cand_cmp.sv
// Qualify one scanned candidate and compare it against the running best.
module rd_cand_cmp
  import rd_sel_pkg::*;
#(
  parameter int unsigned AMT_W  = 9,
  parameter int unsigned WAIT_W = HEAD_WAIT_W
) (
  input  logic                  scan_valid,
  input  logic                  rd_accessible,
  input  logic [AMT_W-1:0]      packet_amount,
  input  logic [WAIT_W-1:0]     head_wait,
  input  logic [SRAM_IDX_W-1:0] cand_sram,
  input  logic                  found,
  input  logic [WAIT_W-1:0]     best_wait,
  input  logic [SRAM_IDX_W-1:0] best_sram,
  output logic                  take,
  output logic                  next_found,
  output logic [WAIT_W-1:0]     next_best_wait,
  output logic [SRAM_IDX_W-1:0] next_best_sram
);

  logic qualify;

  assign qualify = scan_valid && rd_accessible && (packet_amount != '0);
  // Strictly greater: on a tie the earlier candidate is kept.
  assign take = qualify && (!found || (head_wait > best_wait));

  assign next_found     = found || qualify;
  assign next_best_wait = take ? head_wait : best_wait;
  assign next_best_sram = take ? cand_sram : best_sram;

endmodule

// File: rtl/port_rd_sram_selector.sv
// Per-output-port picker of the SRAM whose head packet has waited longest,
// presented to the port's read front end over a valid/ready handshake.
module port_rd_sram_selector
  import rd_sel_pkg::*;
#(
  parameter int unsigned SRAM_NUM = 32,
  parameter int unsigned AMT_W    = 9,
  parameter int unsigned WAIT_W   = HEAD_WAIT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SRAM_IDX_W-1:0] scan_threshold,
  input  logic                  select_enable,
  output logic                  select_valid,
  input  logic                  select_ready,
  output logic [SRAM_SEL_W-1:0] select_sram,
  input  logic                  scan_valid,
  input  logic [SRAM_IDX_W-1:0] scan_sram,
  input  logic                  rd_accessible,
  input  logic [AMT_W-1:0]      packet_amount,
  input  logic [WAIT_W-1:0]     head_wait
);

  localparam logic [SRAM_SEL_W-1:0] SelNone = SRAM_SEL_W'(SRAM_NUM);

  rd_sel_state_e         state_q, state_d;
  logic [SRAM_IDX_W-1:0] tick_q, tick_d;
  logic                  found_q, found_d;
  logic [WAIT_W-1:0]     best_wait_q, best_wait_d;
  logic [SRAM_IDX_W-1:0] best_sram_q, best_sram_d;

  logic                  take;
  logic                  next_found;
  logic [WAIT_W-1:0]     next_best_wait;
  logic [SRAM_IDX_W-1:0] next_best_sram;

  rd_cand_cmp #(
    .AMT_W  (AMT_W),
    .WAIT_W (WAIT_W)
  ) u_cand_cmp (
    .scan_valid     (scan_valid),
    .rd_accessible  (rd_accessible),
    .packet_amount  (packet_amount),
    .head_wait      (head_wait),
    .cand_sram      (scan_sram),
    .found          (found_q),
    .best_wait      (best_wait_q),
    .best_sram      (best_sram_q),
    .take           (take),
    .next_found     (next_found),
    .next_best_wait (next_best_wait),
    .next_best_sram (next_best_sram)
  );

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    found_d     = found_q;
    best_wait_d = best_wait_q;
    best_sram_d = best_sram_q;
    case (state_q)
      ST_IDLE: begin
        // Candidates on the entry cycle are ignored; the sweep starts next cycle.
        if (select_enable) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (!select_enable) begin
          state_d     = ST_IDLE;
          tick_d      = '0;
          found_d     = 1'b0;
          best_wait_d = '0;
        end else if (scan_valid) begin
          if (tick_q == scan_threshold) begin
            tick_d      = '0;
            found_d     = 1'b0;
            best_wait_d = '0;
            if (next_found) begin
              state_d     = ST_DONE;
              best_sram_d = next_best_sram;
            end
          end else begin
            tick_d      = tick_q + 5'd1;
            found_d     = next_found;
            best_wait_d = next_best_wait;
            best_sram_d = next_best_sram;
          end
        end
      end
      ST_DONE: begin
        if (select_ready) begin
          state_d     = ST_IDLE;
          tick_d      = '0;
          found_d     = 1'b0;
          best_wait_d = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        tick_d      = '0;
        found_d     = 1'b0;
        best_wait_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      found_q     <= 1'b0;
      best_wait_q <= '0;
      best_sram_q <= '0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      found_q     <= found_d;
      best_wait_q <= best_wait_d;
      best_sram_q <= best_sram_d;
    end
  end

  // best_sram_q is only exposed while a selection is held, so valid implies < 32.
  assign select_valid = (state_q == ST_DONE);
  assign select_sram  = select_valid ? {1'b0, best_sram_q} : SelNone;

endmodule

// File: doc/port_rd_sram_selector.md
Name: port_rd_sram_selector

Overview:
- Read-side counterpart of the per-port write SRAM matcher.
- For one output port, it watches the backend's rotating SRAM scan. Among SRAMs that hold packets for this port, it picks the one whose head packet has waited longest.
- It presents the chosen SRAM to the port's read front end with a valid/ready handshake.
- Sits between the output-port transmit FSM (front) and the shared SRAM status scan bus (back).

Parameters:
- SRAM_NUM, 32, number of SRAM banks scanned; index width is 5, select width is 6.
- AMT_W, 9, width of per-port packet count in one SRAM.
- WAIT_W, 10, width of head-packet wait counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- scan_threshold  in  5  candidates evaluated per decision = scan_threshold+1.
- select_enable  in  1  front end requests a source SRAM; level signal.
- select_valid  out  1  selection presented.
- select_ready  in  1  front end accepts the selection.
- select_sram  out  6  chosen SRAM index; 6'd32 = none.
- scan_valid  in  1  backend candidate valid this cycle.
- scan_sram  in  5  candidate SRAM index.
- rd_accessible  in  1  candidate SRAM read port not held by another output port.
- packet_amount  in  AMT_W  packets queued for this port in the candidate.
- head_wait  in  WAIT_W  cycles the candidate's head packet for this port has waited (saturating, produced upstream).

Behaviour:
- Reset values: select_valid=0, select_sram=6'd32; internal state=IDLE, tick=0, found=0, best_wait=0.
- States: IDLE(0), SCAN(1), DONE(2); encoding 3 unused, recovers to IDLE.
- IDLE:
  - select_enable=1 -> SCAN next cycle.
  - Candidates presented in the same cycle as the IDLE->SCAN transition are ignored (one-cycle lag).
- A candidate qualifies when all hold: scan_valid, rd_accessible, packet_amount != 0.
- SCAN, each cycle with scan_valid=1:
  - tick increments.
  - A qualifying candidate replaces the current best if found=0 or head_wait > best_wait (strictly greater).
  - Ties keep the earlier candidate.
- SCAN, cycles with scan_valid=0: no tick, no update.
- Decision happens on the scan_valid cycle where tick == scan_threshold. The current candidate is included (next_found/next_best):
  - next_found=1 -> DONE. select_valid=1 and select_sram=next_best from the following cycle.
  - next_found=0 -> stay in SCAN. tick, found and best_wait clear; the sweep restarts with no output.
- select_enable dropping while in SCAN -> IDLE next cycle. Clear tick, found, best_wait; select_sram=32.
- DONE:
  - select_valid and select_sram are held stable until select_ready=1, regardless of select_enable or scan activity.
  - select_valid=1 and select_ready=1 in the same cycle -> IDLE. select_valid=0 and select_sram=32 next cycle; tick, found and best_wait clear.
- Back-to-back operation: if select_enable is still high in IDLE, SCAN is re-entered the next cycle. Minimum gap between handshakes is threshold+3 cycles.
- Width rules:
  - tick is 5 bits and never exceeds the threshold; it clears at every decision.
  - head_wait compares unsigned; packet_amount is only zero-tested.
- select_valid=1 ⇒ select_sram<32.
- Reset mid-operation (any state) returns everything to reset values on the next edge. No partial handshake survives.

Decomposition:
- Shared package rd_sel_pkg:
  - constants SRAM_NONE=6'd32, SRAM_IDX_W=5.
  - state encoding ST_IDLE/ST_SCAN/ST_DONE.
  - head_wait width type, shared with the head-wait tracker.
- One sub-module is natural: rd_cand_cmp. It is a combinational qualify-and-compare of a candidate vs current best and outputs take/next_found. Reuse it later for priority-aware variants.
- Remaining FSM, tick and registers stay in the top module.

Test Plan:
- Threshold=3, enable high, candidates SRAM 4/5/6/7 all accessible, amounts 2/0/1/3, waits 10/99/20/20 -> SRAM5 is skipped (amount 0). select_valid rises 1 cycle after SRAM7; select_sram=6 (tie with 7 keeps the earlier one).
- Threshold=1, candidates SRAM 2/3 with rd_accessible=0 then SRAM 8/9 accessible with waits 5/7 -> first sweep silently restarts with no valid. select_sram=9 after the second sweep.
- Selection presented, select_ready held 0 for 5 cycles while enable drops and scan continues -> select_valid=1 and select_sram unchanged all 5 cycles. Ready=1 -> valid=0 and select_sram=32 next cycle.
- Enable high, scan_valid toggling 1/0/1/0 with threshold=2 -> decision only after the 3rd valid candidate; the tick is observed not to advance on gaps.
- Enable dropped after 2 of 4 candidates (threshold=3) -> IDLE, no valid. Re-enable -> a fresh 4-candidate sweep; the earlier best is not retained.
- rst_n=0 asserted one cycle while in DONE -> select_valid=0, select_sram=32 next edge. After release with enable high, the FSM enters SCAN again.
